// File: rtl/prewish_pkg.sv
// Shared definitions for the prewish button poller: state encoding, byte width,
// default timing values and the rising-edge helper.
package prewish_pkg;

  localparam int PREWISH_DW              = 8;
  localparam int PREWISH_POLL_DEFAULT    = 1200;
  localparam int PREWISH_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b11,
    ST_EVAL = 2'b10
  } poller_state_t;

  function automatic logic [PREWISH_DW-1:0] rise_bits(input logic [PREWISH_DW-1:0] cur,
                                                      input logic [PREWISH_DW-1:0] prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/prewish_downcounter.sv
// Loadable down-counter with asynchronous reset; it saturates at zero and
// reports zero combinationally.
module prewish_downcounter
  import prewish_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/prewish_button_poller.sv
// Polls the prewish debouncer over the STB/DAT handshake, detects new presses and
// keeps a toggle mask. Optional auto-repeat: define PREWISH_POLLER_AUTOREPEAT_EN.
module prewish_button_poller
  import prewish_pkg::*;
#(
  parameter int                    POLL_CYCLES    = PREWISH_POLL_DEFAULT,
  parameter int                    TIMEOUT_CYCLES = PREWISH_TIMEOUT_DEFAULT,
  parameter logic [PREWISH_DW-1:0] ENABLE_MASK    = 8'hFF,
  parameter int                    REPEAT_POLLS   = 50
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  output logic                  STB_O,
  output logic [PREWISH_DW-1:0] DAT_O,
  input  logic                  STB_I,
  input  logic [PREWISH_DW-1:0] DAT_I,
  output logic [PREWISH_DW-1:0] o_status,
  output logic [PREWISH_DW-1:0] o_pressed,
  output logic [PREWISH_DW-1:0] o_mask,
  output logic                  o_timeout,
  output logic                  o_alive
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

  if (POLL_CYCLES < 2 || TIMEOUT_CYCLES < 4 || REPEAT_POLLS < 1) begin : g_param_check
    $error("prewish_button_poller: illegal parameter value");
  end

  poller_state_t state, state_next;
  logic poll_load, poll_dec, poll_zero;
  logic tmo_load, tmo_dec, tmo_zero;
  logic capture, tmo_hit, eval;
  logic [PW-1:0] poll_count;
  logic [TW-1:0] tmo_count;
  logic [PREWISH_DW-1:0] captured, new_pressed, prev;

  prewish_downcounter #(.WIDTH(PW), .RESET_VAL(POLL_LOAD)) u_poll_cnt (
    .clk(CLK_I), .rst(RST_I), .load(poll_load), .load_value(POLL_LOAD),
    .dec(poll_dec), .count(poll_count), .zero(poll_zero)
  );

  prewish_downcounter #(.WIDTH(TW), .RESET_VAL(TMO_LOAD)) u_tmo_cnt (
    .clk(CLK_I), .rst(RST_I), .load(tmo_load), .load_value(TMO_LOAD),
    .dec(tmo_dec), .count(tmo_count), .zero(tmo_zero)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    poll_load  = 1'b0;
    poll_dec   = 1'b0;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;
    capture    = 1'b0;
    tmo_hit    = 1'b0;
    eval       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (poll_zero) state_next = ST_REQ;
        else           poll_dec   = 1'b1;
      end
      ST_REQ: begin
        tmo_load   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (STB_I) begin
          capture    = 1'b1;
          state_next = ST_EVAL;
        end else if (tmo_zero) begin
          tmo_hit    = 1'b1;
          poll_load  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_EVAL: begin
        eval       = 1'b1;
        poll_load  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign STB_O    = (state == ST_REQ);
  assign DAT_O    = ENABLE_MASK;
  assign captured = DAT_I & ENABLE_MASK;

`ifdef PREWISH_POLLER_AUTOREPEAT_EN
  logic [7:0] hold;
  logic       held, repeat_fire;

  // A hold counts a poll whose non-zero status matches the previous one.
  assign held        = (captured != '0) && (captured == prev);
  assign repeat_fire = held && (hold == 8'(REPEAT_POLLS - 1));
  assign new_pressed = rise_bits(captured, prev) | (repeat_fire ? captured : '0);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      hold <= '0;
    end else if (capture) begin
      if (held && !repeat_fire) hold <= hold + 8'd1;
      else                      hold <= '0;
    end
  end
`else
  assign new_pressed = rise_bits(captured, prev);
`endif

  // o_pressed is loaded at capture so it is visible only during the EVAL cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      o_status  <= '0;
      o_pressed <= '0;
      o_mask    <= '0;
      prev      <= '0;
      o_timeout <= 1'b0;
      o_alive   <= 1'b0;
    end else begin
      o_pressed <= '0;
      if (capture) begin
        o_status  <= captured;
        o_pressed <= new_pressed;
      end
      if (eval) begin
        o_mask  <= o_mask ^ o_pressed;
        prev    <= o_status;
        o_alive <= ~o_alive;
      end
      if (tmo_hit) o_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prewish_button_poller.sv
// Randomized self-checking bench for prewish_button_poller with a transaction-level
// model of the poll/press/toggle rules and a debouncer stand-in driving STB_I/DAT_I.
module tb_prewish_button_poller;

  localparam int         POLL  = 4;
  localparam int         TMO   = 4;
  localparam int         REP   = 3;
  localparam logic [7:0] EMASK = 8'h1F;

  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic       STB_O, STB_I;
  logic [7:0] DAT_O, DAT_I;
  logic [7:0] o_status, o_pressed, o_mask;
  logic       o_timeout, o_alive;

  always #5 CLK_I = ~CLK_I;

  prewish_button_poller #(
    .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .ENABLE_MASK(EMASK), .REPEAT_POLLS(REP)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_O(STB_O), .DAT_O(DAT_O), .STB_I(STB_I),
    .DAT_I(DAT_I), .o_status(o_status), .o_pressed(o_pressed), .o_mask(o_mask),
    .o_timeout(o_timeout), .o_alive(o_alive)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_status, m_prev, m_mask;
  logic       m_alive, m_timeout;
  int         m_hold;
  int         next_gap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic model_reset();
    m_status = 8'h00; m_prev = 8'h00; m_mask = 8'h00;
    m_alive = 1'b0; m_timeout = 1'b0; m_hold = 0;
  endtask

  // Expected press vector for a completed poll returning raw byte v; updates the model.
  function automatic logic [7:0] model_poll(input logic [7:0] v);
    logic [7:0] s, p;
    s = v & EMASK;
    p = s & ~m_prev;
`ifdef PREWISH_POLLER_AUTOREPEAT_EN
    if (s != 8'h00 && s == m_prev) begin
      m_hold++;
      if (m_hold == REP) begin
        p = s;
        m_hold = 0;
      end
    end else begin
      m_hold = 0;
    end
`endif
    m_status = s;
    m_mask   = m_mask ^ p;
    m_prev   = s;
    m_alive  = ~m_alive;
    return p;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_status"}, o_status, m_status);
    check({tag, "_mask"}, o_mask, m_mask);
    check({tag, "_timeout"}, o_timeout, m_timeout);
    check({tag, "_alive"}, o_alive, m_alive);
  endtask

  task automatic reset_now(input string tag);
    RST_I = 1'b1;
    STB_I = 1'b0;
    #2;
    model_reset();
    check({tag, "_stb"}, STB_O, 1'b0);
    check({tag, "_pressed"}, o_pressed, 8'h00);
    check_state(tag);
    tick();
    tick();
    RST_I = 1'b0;
    next_gap = POLL;
  endtask

  // Waits for the request strobe with spurious STB_I traffic in between.
  task automatic wait_req(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < next_gap + 4) begin
      STB_I = ($urandom_range(0, 3) == 0);
      DAT_I = 8'($urandom);
      tick();
      n++;
      if (STB_O) break;
      check("idle_pressed", o_pressed, 8'h00);
    end
    STB_I = 1'b0;
    ok = STB_O;
    check("req_seen", STB_O, 1'b1);
    check("req_gap", n, next_gap);
    check("dat_o", DAT_O, EMASK);
  endtask

  // delay: cycle after the request in which STB_I is raised; 0 = no response.
  task automatic do_poll(input logic [7:0] data, input int delay);
    bit ok;
    logic [7:0] p;
    wait_req(ok);
    if (!ok) return;
    tick();
    check("req_width", STB_O, 1'b0);
    if (delay >= 2 && delay <= TMO) begin
      repeat (delay - 1) tick();
      STB_I = 1'b1;
      DAT_I = data;
      tick();
      STB_I = 1'b0;
      DAT_I = 8'($urandom);
      p = model_poll(data);
      check("eval_pressed", o_pressed, p);
      check("eval_status", o_status, m_status);
      tick();
      check("post_pressed", o_pressed, 8'h00);
      check_state("post");
      next_gap = POLL;
    end else begin
      repeat (TMO - 1) tick();
      check("pre_timeout", o_timeout, m_timeout);
      tick();
      m_timeout = 1'b1;
      check("tmo_pressed", o_pressed, 8'h00);
      check_state("tmo");
      next_gap = POLL;
      if (delay == TMO + 1) begin
        STB_I = 1'b1;
        DAT_I = data;
        tick();
        STB_I = 1'b0;
        check("late_pressed", o_pressed, 8'h00);
        check_state("late");
        next_gap = POLL - 1;
      end
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] last, d;
    int dly;
    STB_I = 1'b0;
    DAT_I = 8'h00;
    RST_I = 1'b1;
    reset_now("rst0");
    check("rst0_dat_o", DAT_O, EMASK);

    do_poll(8'h01, 2);
    check("first_press_mask", o_mask, 8'h01);
    do_poll(8'h01, 2);
    check("held_mask", o_mask, 8'h01);

    // Reset abandoned mid-handshake.
    wait_req(ok);
    tick();
    reset_now("rst_wait");

    do_poll(8'h05, 2);
    do_poll(8'h04, 3);
    do_poll(8'h06, 2);
    check("seq_mask_end", o_mask, 8'h07);

    do_poll(8'hAA, 0);
    do_poll(8'h01, TMO + 1);
    do_poll(8'h00, TMO);

    do_poll(8'hF3, 2);
    check("masked_status", o_status, 8'h13);

    repeat (8) do_poll(8'h10, 2);

    last = 8'h00;
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 2) == 0) ? last : 8'($urandom);
      dly = $urandom_range(0, TMO + 1);
      if (dly == 1) dly = 2;
      do_poll(d, dly);
      last = d;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prewish_button_poller.md
Name: prewish_button_poller

Overview:
- Downstream consumer of prewish_debounce's status byte.
- Periodically strobes the debouncer over the STB/DAT handshake, captures the returned active-high button byte and detects newly pressed buttons.
- Maintains a toggle mask that feeds the blinky pattern logic.
- Single clock domain, the same as the debouncer's CLK_I.

Parameters:
- POLL_CYCLES, 1200: CLK_I cycles between the end of one poll and the next request; must be ≥ 2.
- TIMEOUT_CYCLES, 16: maximum cycles to wait for the response strobe after a request; must be ≥ 4.
- ENABLE_MASK, 8'hFF: bits of the status byte that are honoured; also driven on DAT_O.
- REPEAT_POLLS, 50: consecutive identical non-zero polls before an auto-repeat fires (optional feature only).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  asynchronous reset, active-high.
- STB_O  out  1  request strobe to the debouncer (its STB_I).
- DAT_O  out  8  request data, driven constantly to ENABLE_MASK.
- STB_I  in  1  response strobe from the debouncer (its STB_O).
- DAT_I  in  8  status byte from the debouncer, active-high per button.
- o_status  out  8  last captured status, equal to DAT_I & ENABLE_MASK.
- o_pressed  out  8  one-cycle pulse of bits that went 0→1 between consecutive polls.
- o_mask  out  8  toggle register, updated as o_mask ^ o_pressed.
- o_timeout  out  1  sticky flag: a response was missed.
- o_alive  out  1  toggles on every completed poll.

Behaviour:
- Reset (async, RST_I high): STB_O=0, o_status=0, o_pressed=0, o_mask=0, o_timeout=0, o_alive=0. State=IDLE, poll counter=POLL_CYCLES-1, previous status=0. Reset mid-handshake simply abandons the transaction.
- IDLE:
  - STB_O=0, o_pressed=0.
  - Counter decrements each cycle; at 0 go to REQ.
- REQ (exactly 1 cycle):
  - STB_O=1, timeout counter loaded with TIMEOUT_CYCLES-1.
  - Next state WAIT.
- WAIT:
  - STB_O=0; the debouncer emits its strobe only after its request input falls.
  - If STB_I=1: capture DAT_I & ENABLE_MASK into the status register, then go to EVAL.
  - Else if the timeout counter is 0: set o_timeout, reload the poll counter, go to IDLE. o_status, o_mask and previous status are unchanged.
  - Else decrement the timeout counter.
- EVAL (1 cycle):
  - o_pressed = status & ~prev (registered, visible for exactly this one cycle after capture).
  - o_mask <= o_mask ^ that value.
  - prev <= status; o_alive toggles.
  - Reload the poll counter, go to IDLE.
- Latency: request strobe to o_pressed pulse is 3 cycles with the current debouncer (WAIT sees STB_I at +2, EVAL at +3).
- STB_I high while in IDLE, REQ or EVAL is ignored; a spurious strobe never updates state.
- o_timeout clears only on reset.
- Release (1→0) produces no pulse.
- A bit simultaneously pressed and masked-off by ENABLE_MASK never appears.
- Counter widths are $clog2 of the parameter; counters never wrap past 0.

Optional Feature:
- Macro: PREWISH_POLLER_AUTOREPEAT_EN.
- With the macro: an 8-bit-capable hold counter tracks consecutive EVALs where status == prev and status != 0.
  - On reaching REPEAT_POLLS, o_pressed = status for that EVAL cycle, o_mask toggles accordingly, and the counter restarts at 0.
  - Any change or an all-zero status clears the counter.
  - A timeout does not clear it.
- Without the macro: no hold counter; o_pressed only ever reflects 0→1 edges.

Decomposition:
- Shared package prewish_pkg:
  - poller state encoding: IDLE=2'b00, REQ=2'b01, WAIT=2'b11, EVAL=2'b10.
  - byte width constant PREWISH_DW=8.
  - default POLL/TIMEOUT values.
- One natural sub-module: prewish_downcounter (loadable, async-reset down-counter with zero flag), instantiated twice for the poll and timeout counts.

Test Plan:
- Reset with POLL_CYCLES=4:
  - All outputs 0.
  - First STB_O pulse 4 cycles after RST_I falls, one cycle wide.
- Debouncer model returns 8'h01 after the request:
  - o_pressed=8'h01 for exactly one cycle; o_mask=8'h01; o_alive=1.
  - Next poll also returns 8'h01: o_pressed stays 0, o_mask stays 8'h01.
- Status 8'h05 then 8'h04 then 8'h06:
  - o_pressed sequence 8'h05, 8'h00, 8'h02.
  - o_mask ends 8'h07.
- Model never responds, TIMEOUT_CYCLES=4:
  - o_timeout rises 5 cycles after STB_O.
  - o_status and o_mask unchanged; polling continues; o_timeout remains set until RST_I.
- ENABLE_MASK=8'h0F, status 8'hF3: o_status=8'h03, o_pressed=8'h03, DAT_O=8'h0F.
- With PREWISH_POLLER_AUTOREPEAT_EN, REPEAT_POLLS=3, status held at 8'h10:
  - Initial press pulse, then o_pressed=8'h10 again on every 3rd subsequent poll.
  - o_mask alternates 8'h10/8'h00.
- Also: RST_I asserted during WAIT clears everything asynchronously.
